// File: rtl/stage_if.sv
// stage_if: instruction-fetch stage feeding the if_id register.
// Builds each 32-bit word from four little-endian byte reads on the shared RAM port.
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_enable_i,
  input  logic [31:0] branch_addr_i,
  input  logic        mem_grant_i,
  input  logic [7:0]  mem_data_i,
  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic {
    FETCH,
    VALID
  } state_e;

  state_e             state_q, state_d;
  logic               run_q;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        buf_q, buf_d;
  logic [2:0]         iss_cnt_q, iss_cnt_d;
  logic [2:0]         rcv_cnt_q, rcv_cnt_d;
  logic [1:0]         drop_cnt_q, drop_cnt_d;
  logic [MEM_LAT-1:0] lat_q, lat_d;

  logic               issue;
  logic               ret;
  logic               take;
  logic [1:0]         due;

  always_comb begin
    issue = run_q && (state_q == FETCH) && mem_grant_i
         && (iss_cnt_q < 3'd4) && (drop_cnt_q == 2'd0);
    ret   = lat_q[MEM_LAT-1];
    take  = ret && (drop_cnt_q == 2'd0) && (state_q == FETCH);
    lat_d = (lat_q << 1) | MEM_LAT'(issue);

    // reads still due after this edge: all of them are stale on a redirect
    due = 2'd0;
    for (int unsigned i = 0; i < MEM_LAT; i++) begin
      due = due + {1'b0, lat_d[i]};
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    iss_cnt_d  = iss_cnt_q;
    rcv_cnt_d  = rcv_cnt_q;
    drop_cnt_d = drop_cnt_q;

    if (issue) begin
      iss_cnt_d = iss_cnt_q + 3'd1;
    end
    if (ret && (drop_cnt_q != 2'd0)) begin
      drop_cnt_d = drop_cnt_q - 2'd1;
    end
    if (take) begin
      buf_d[{rcv_cnt_q[1:0], 3'b000} +: 8] = mem_data_i;
      rcv_cnt_d = rcv_cnt_q + 3'd1;
      if (rcv_cnt_q == 3'd3) begin
        state_d = VALID;
      end
    end

    if (branch_enable_i) begin
      pc_d       = branch_addr_i;
      iss_cnt_d  = 3'd0;
      rcv_cnt_d  = 3'd0;
      drop_cnt_d = due;
      state_d    = FETCH;
    end else if ((state_q == VALID) && !stall_i) begin
      pc_d       = pc_q + 32'd4;
      iss_cnt_d  = 3'd0;
      rcv_cnt_d  = 3'd0;
      drop_cnt_d = 2'd0;
      state_d    = FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      run_q      <= 1'b0;
      pc_q       <= RESET_PC;
      buf_q      <= 32'd0;
      iss_cnt_q  <= 3'd0;
      rcv_cnt_q  <= 3'd0;
      drop_cnt_q <= 2'd0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      iss_cnt_q  <= iss_cnt_d;
      rcv_cnt_q  <= rcv_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      lat_q      <= lat_d;
    end
  end

  assign mem_rd_o     = issue;
  assign mem_addr_o   = issue ? (pc_q + {29'd0, iss_cnt_q}) : 32'd0;
  assign pc_o         = pc_q;
  assign inst_valid_o = (state_q == VALID);
  assign inst_o       = inst_valid_o ? buf_q : 32'd0;

endmodule

// File: tb/tb_stage_if.sv
// tb_stage_if: two lanes (MEM_LAT 1 and 3), directed tests then random traffic.
// A byte-RAM responder feeds each DUT; a monitor scores it against a PC/word model.
module tb_stage_if;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: begin
        h = a * 32'h9E37_79B1;
        return h[31:24] ^ h[7:0] ^ 8'h5A;
      end
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2),
            mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  task automatic chk(input int lane, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lat%0d %s: got %h expected %h t=%0t",
               lane, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;

    logic        rst_l;
    logic        stall;
    logic        br;
    logic [31:0] baddr;
    logic        grant;
    logic [7:0]  mdata;
    logic        mrd;
    logic [31:0] maddr;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        vld;
    int          deliv = 0;

    stage_if #(
      .RESET_PC(32'h0000_0000),
      .MEM_LAT (LAT)
    ) dut (
      .clk            (clk),
      .rst            (rst_l),
      .stall_i        (stall),
      .branch_enable_i(br),
      .branch_addr_i  (baddr),
      .mem_grant_i    (grant),
      .mem_data_i     (mdata),
      .mem_rd_o       (mrd),
      .mem_addr_o     (maddr),
      .pc_o           (pc),
      .inst_o         (inst),
      .inst_valid_o   (vld)
    );

    // RAM responder: byte for an issue in cycle c appears in cycle c+LAT
    logic [32:0] hist[$];
    initial begin
      mdata = 8'h00;
      for (int i = 0; i < LAT; i++) hist.push_back(33'd0);
    end
    always @(negedge clk) begin
      hist.push_back({mrd, maddr});
      void'(hist.pop_front());
    end
    always @(posedge clk) begin
      #1;
      if (hist[0][32]) mdata = mem_byte(hist[0][31:0]);
      else             mdata = 8'($urandom);
    end

    // Scoreboard monitor: exp_q holds the PC the next delivery must carry
    logic [31:0] exp_q[$];
    logic [31:0] hpc, hinst;
    int          iss_n = 0;
    bit          seen  = 0;

    always @(negedge clk) begin
      if (!rst_l) begin
        chk(LAT, "rst_mrd", 32'(mrd), 32'd0);
        chk(LAT, "rst_addr", maddr, 32'd0);
        chk(LAT, "rst_pc", pc, 32'd0);
        chk(LAT, "rst_inst", inst, 32'd0);
        chk(LAT, "rst_vld", 32'(vld), 32'd0);
        exp_q.delete();
        exp_q.push_back(32'd0);
        iss_n = 0;
        seen  = 0;
      end else begin
        chk(LAT, "pc", pc, exp_q[0]);
        if (!vld) chk(LAT, "bubble_inst", inst, 32'd0);
        if (mrd) begin
          chk(LAT, "rd_grant", 32'(grant), 32'd1);
          chk(LAT, "rd_not_valid", 32'(vld), 32'd0);
          chk(LAT, "rd_addr", maddr, exp_q[0] + 32'(iss_n));
          iss_n++;
          chk(LAT, "rd_count", 32'(iss_n <= 4), 32'd1);
        end else begin
          chk(LAT, "idle_addr", maddr, 32'd0);
        end
        if (vld) begin
          if (!seen) begin
            chk(LAT, "deliv_inst", inst, word_at(exp_q[0]));
            chk(LAT, "deliv_issues", 32'(iss_n), 32'd4);
            hpc   = pc;
            hinst = inst;
            seen  = 1;
            deliv++;
          end else begin
            chk(LAT, "held_pc", pc, hpc);
            chk(LAT, "held_inst", inst, hinst);
          end
        end
        if (br) begin
          exp_q.delete();
          exp_q.push_back(baddr);
          iss_n = 0;
          seen  = 0;
        end else if (vld && !stall) begin
          void'(exp_q.pop_front());
          exp_q.push_back(hpc + 32'd4);
          iss_n = 0;
          seen  = 0;
        end
      end
    end

    initial begin : stim
      int v;
      int d0;
      v     = 4 + LAT;
      rst_l = 1'b0;
      stall = 1'b0;
      br    = 1'b0;
      baddr = 32'd0;
      grant = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_l = 1'b1;
      stall = 1'b1;

      // first fetch from reset, then a 3-cycle stall and release
      for (int k = 0; k <= v + 4; k++) begin
        @(posedge clk);
        #1;
        if (k == v + 3) stall = 1'b0;
        #1;
        if (k < 4) begin
          chk(LAT, "t1_rd", 32'(mrd), 32'd1);
          chk(LAT, "t1_addr", maddr, 32'(k));
        end
        if (k <= v) chk(LAT, "t1_valid", 32'(vld), 32'(k == v));
        if (k >= v && k <= v + 3) begin
          chk(LAT, "t2_pc", pc, 32'd0);
          chk(LAT, "t2_inst", inst, 32'h0010_0513);
          chk(LAT, "t2_rd", 32'(mrd), 32'd0);
          chk(LAT, "t2_vld", 32'(vld), 32'd1);
        end
        if (k == v + 4) begin
          chk(LAT, "t2_next_pc", pc, 32'd4);
          chk(LAT, "t2_next_vld", 32'(vld), 32'd0);
          chk(LAT, "t2_next_inst", inst, 32'd0);
          chk(LAT, "t2_next_rd", 32'(mrd), 32'd1);
          chk(LAT, "t2_next_addr", maddr, 32'd4);
        end
      end

      // grant withheld for two cycles before byte 2
      for (int j = 1; j <= v + 2; j++) begin
        @(posedge clk);
        #1;
        grant = !(j == 2 || j == 3);
        #1;
        chk(LAT, "t3_valid", 32'(vld), 32'(j == v + 2));
        if (j == v + 2) begin
          chk(LAT, "t3_pc", pc, 32'd4);
          chk(LAT, "t3_inst", inst, word_at(32'd4));
        end
      end

      // redirect right after the byte-1 issue
      for (int c = 0; c <= 7 + 2 * LAT; c++) begin
        @(posedge clk);
        #1;
        br    = (c == 2);
        baddr = 32'h100;
        #1;
        if (c < 3) begin
          chk(LAT, "t4_rd", 32'(mrd), 32'd1);
          chk(LAT, "t4_addr", maddr, 32'(8 + c));
        end else if (c < 3 + LAT) begin
          chk(LAT, "t4_drop_rd", 32'(mrd), 32'd0);
        end else if (c <= 6 + LAT) begin
          chk(LAT, "t4_new_rd", 32'(mrd), 32'd1);
          chk(LAT, "t4_new_addr", maddr, 32'h100 + 32'(c - 3 - LAT));
        end
        if (c >= 3) chk(LAT, "t4_pc", pc, 32'h100);
        chk(LAT, "t4_valid", 32'(vld), 32'(c == 7 + 2 * LAT));
      end
      chk(LAT, "t4_inst", inst, word_at(32'h100));

      // stall and redirect together while valid
      stall = 1'b1;
      br    = 1'b1;
      baddr = 32'h40;
      @(posedge clk);
      #1;
      br    = 1'b0;
      stall = 1'b0;
      #1;
      chk(LAT, "t5_pc", pc, 32'h40);
      chk(LAT, "t5_vld", 32'(vld), 32'd0);
      chk(LAT, "t5_inst", inst, 32'd0);
      chk(LAT, "t5_addr", maddr, 32'h40);

      // asynchronous reset mid-fetch, then a clean restart
      @(posedge clk);
      #3;
      rst_l = 1'b0;
      #1;
      chk(LAT, "t6_rd", 32'(mrd), 32'd0);
      chk(LAT, "t6_addr", maddr, 32'd0);
      chk(LAT, "t6_pc", pc, 32'd0);
      chk(LAT, "t6_inst", inst, 32'd0);
      chk(LAT, "t6_vld", 32'(vld), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_l = 1'b1;
      for (int k = 0; k <= v; k++) begin
        @(posedge clk);
        #2;
        if (k < 4) chk(LAT, "t6_re_addr", maddr, 32'(k));
        chk(LAT, "t6_re_valid", 32'(vld), 32'(k == v));
        if (k == v) chk(LAT, "t6_re_inst", inst, 32'h0010_0513);
      end

      // random traffic
      for (int n = 0; n < 400; n++) begin
        @(posedge clk);
        #1;
        grant = ($urandom_range(0, 3) != 0);
        stall = ($urandom_range(0, 2) == 0);
        br    = ($urandom_range(0, 11) == 0);
        case ($urandom_range(0, 3))
          0:       baddr = 32'h100 + 32'($urandom_range(0, 15));
          1:       baddr = 32'hFFFF_FFFE;
          2:       baddr = $urandom;
          default: baddr = $urandom & 32'hFFFF_FFFC;
        endcase
        if ($urandom_range(0, 149) == 0) begin
          rst_l = 1'b0;
          @(posedge clk);
          #1;
          rst_l = 1'b1;
        end
      end

      // drain: free-running fetch must keep delivering
      grant = 1'b1;
      stall = 1'b0;
      br    = 1'b0;
      d0    = deliv;
      repeat (40) @(posedge clk);
      chk(LAT, "drain_progress", 32'(deliv > d0 + 2), 32'd1);
      done_cnt++;
    end
  end

  initial begin
    fork
      wait (done_cnt == 2);
      begin
        #500000;
        checks++;
        errors++;
        $display("FAIL timeout: lanes done %0d of 2", done_cnt);
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
